// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//    Definitions shared by the frequency meter: FSM state encoding, the
//    result width (the Hz format used by the frequency-word generators) and
//    the set of legal gate divisors.
package freq_meter_pkg;

   // Result width in Hz.
   localparam int unsigned FREQ_W = 32;

   // Measurement FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GATE = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Gate divisors supported by the meter (gate = CLKREF/div cycles).
   localparam logic [31:0] GATE_DIV_1    = 32'd1;
   localparam logic [31:0] GATE_DIV_10   = 32'd10;
   localparam logic [31:0] GATE_DIV_100  = 32'd100;
   localparam logic [31:0] GATE_DIV_1000 = 32'd1000;

   // True when div is one of the supported gate divisors.
   function automatic logic gate_div_legal(input logic [31:0] div);
      logic ok;
      case (div)
         GATE_DIV_1, GATE_DIV_10, GATE_DIV_100, GATE_DIV_1000: ok = 1'b1;
         default:                                              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge
//    Brings an asynchronous input into the clk domain through a 2-FF
//    synchronizer and emits a one-cycle pulse on each synchronized rising
//    edge. A third flop holds the previous synchronized level for the edge
//    compare, so the pulse never depends on the metastable first stage.
//    Latency from a d_i rising edge to pulse_o is 2-3 clk cycles.
// Ports:
//    clk      reference clock
//    rst_n    asynchronous active-low reset (all flops cleared)
//    d_i      asynchronous input
//    pulse_o  one-cycle pulse per rising edge of d_i
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic sync_qq;

   // Synchronizer chain plus previous-level flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         sync_qq <= 1'b0;
      end else begin
         meta_q  <= d_i;
         sync_q  <= meta_q;
         sync_qq <= sync_q;
      end
   end

   // Both operands are flop outputs, so the pulse is clean for one cycle.
   assign pulse_o = sync_q & ~sync_qq;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//    Counts rising edges of an asynchronous input over a gate of
//    GATE_CYCLES = CLKREF/GATE_DIV clk cycles and reports edges*GATE_DIV,
//    i.e. the input frequency in Hz. Single-shot (start) or back-to-back
//    (cont) measurements; one dead cycle (DONE) between windows.
// Ports:
//    clk       reference clock, CLKREF Hz
//    rst_n     asynchronous active-low reset
//    sig_in    signal to measure (asynchronous, 0 .. CLKREF/4 Hz)
//    start     single-cycle measurement request, honoured only in IDLE
//    cont      continuous-mode level, checked in IDLE and in DONE
//    freq_out  last measured frequency in Hz, held until the next result
//    freq_vld  one-cycle pulse in the cycle freq_out takes a new value
//    busy      high while in GATE or DONE
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter logic [31:0] CLKREF   = 32'd256_000_000,
   parameter logic [31:0] GATE_DIV = 32'd1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sig_in,
   input  logic              start,
   input  logic              cont,
   output logic [FREQ_W-1:0] freq_out,
   output logic              freq_vld,
   output logic              busy
);

   localparam logic [31:0] GATE_CYCLES = CLKREF / GATE_DIV;

   // Elaboration-time parameter sanity.
   if (!gate_div_legal(GATE_DIV)) begin : g_div_illegal
      $error("freq_meter: GATE_DIV must be 1, 10, 100 or 1000");
   end
   if ((CLKREF % GATE_DIV) != 32'd0) begin : g_div_inexact
      $error("freq_meter: GATE_DIV must divide CLKREF exactly");
   end

   logic              edge_p;
   state_e            state_q;
   logic [31:0]       gate_cnt_q;
   logic [31:0]       edge_cnt_q;
   logic [FREQ_W-1:0] freq_out_q;
   logic              freq_vld_q;
   logic              busy_q;
   logic [FREQ_W-1:0] freq_scaled_d;

   sync_edge u_sync_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_i     (sig_in),
      .pulse_o (edge_p)
   );

   // Constant multiply; edge_cnt <= GATE_CYCLES/2 keeps the product < 2^32.
   assign freq_scaled_d = edge_cnt_q * GATE_DIV;

   // Measurement FSM with counters and registered outputs. busy_q is
   // written alongside every state change so it always equals
   // (state_q != ST_IDLE).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gate_cnt_q <= 32'd0;
         edge_cnt_q <= 32'd0;
         freq_out_q <= 32'd0;
         freq_vld_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         freq_vld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start || cont) begin
                  state_q    <= ST_GATE;
                  gate_cnt_q <= 32'd0;
                  edge_cnt_q <= 32'd0;
                  busy_q     <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_GATE: begin
               gate_cnt_q <= gate_cnt_q + 32'd1;
               if (edge_p) begin
                  edge_cnt_q <= edge_cnt_q + 32'd1;
               end else begin
                  edge_cnt_q <= edge_cnt_q;
               end
               // The last gate cycle still counts its edge (above).
               if (gate_cnt_q == GATE_CYCLES - 32'd1) begin
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_GATE;
               end
               busy_q <= 1'b1;
            end
            ST_DONE: begin
               // Edges seen in this cycle are dropped: the window dead time.
               freq_out_q <= freq_scaled_d;
               freq_vld_q <= 1'b1;
               if (cont) begin
                  state_q    <= ST_GATE;
                  gate_cnt_q <= 32'd0;
                  edge_cnt_q <= 32'd0;
                  busy_q     <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign freq_out = freq_out_q;
   assign freq_vld = freq_vld_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
//    Scoreboard bench for freq_meter. Two instances at CLKREF=1000:
//    u_dut1 (GATE_DIV=1, gate 1000 cycles) and u_dut10 (GATE_DIV=10, gate
//    100 cycles). sig_in is a periodic square wave with period P; any run of
//    G consecutive gate cycles contains exactly G/P edge pulses when P divides
//    G, so the expected result is G/P*GATE_DIV regardless of phase. Each
//    expectation carries the value and the cycle counter value at which
//    freq_vld must be seen (start set at cycle c -> result at c+G+2).
module tb_freq_meter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sig_in = 1'b0;
   logic        start1 = 1'b0;
   logic        cont1 = 1'b0;
   logic        start10 = 1'b0;
   logic        cont10 = 1'b0;
   logic [31:0] fo1;
   logic [31:0] fo10;
   logic        vld1;
   logic        vld10;
   logic        busy1;
   logic        busy10;

   typedef struct {
      logic [31:0] freq;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q10[$];
   exp_t e1;
   exp_t e10;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   gen_p = 0;
   int   gen_base = 0;
   int   c;

   freq_meter #(.CLKREF(32'd1000), .GATE_DIV(32'd1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start1), .cont(cont1),
      .freq_out(fo1), .freq_vld(vld1), .busy(busy1)
   );

   freq_meter #(.CLKREF(32'd1000), .GATE_DIV(32'd10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start10), .cont(cont10),
      .freq_out(fo10), .freq_vld(vld10), .busy(busy10)
   );

   always #5 clk = ~clk;

   // Posedge counter used to timestamp results.
   always @(posedge clk) cyc <= cyc + 1;

   // Square-wave generator, changes on negedges.
   always @(negedge clk) begin
      if (gen_p == 0) sig_in = 1'b0;
      else            sig_in = (((cyc - gen_base) % gen_p) < (gen_p / 2));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for u_dut1.
   always @(negedge clk) begin
      if (vld1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dut1_unexpected_vld: got result %0d at cycle %0d, expected none", fo1, cyc);
         end else begin
            e1 = q1.pop_front();
            chk("dut1_freq_out", fo1, e1.freq);
            chk("dut1_vld_cycle", cyc, e1.cyc);
         end
      end
   end

   // Monitor for u_dut10.
   always @(negedge clk) begin
      if (vld10 === 1'b1) begin
         if (q10.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dut10_unexpected_vld: got result %0d at cycle %0d, expected none", fo10, cyc);
         end else begin
            e10 = q10.pop_front();
            chk("dut10_freq_out", fo10, e10.freq);
            chk("dut10_vld_cycle", cyc, e10.cyc);
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_empty(input int sel, input int budget);
      int n = 0;
      while ((((sel == 1) ? q1.size() : q10.size()) != 0) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (((sel == 1) ? q1.size() : q10.size()) != 0) begin
         failures++;
         $display("FAIL timeout_dut%0d: got %0d pending results expected 0", sel,
                  (sel == 1) ? q1.size() : q10.size());
         if (sel == 1) q1.delete();
         else          q10.delete();
      end
   endtask

   task automatic set_gen(input int p);
      gen_p    = p;
      gen_base = cyc;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_fo1", fo1, 32'd0);
      chk("rst_vld1", {31'd0, vld1}, 32'd0);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      chk("rst_fo10", fo10, 32'd0);
      chk("rst_vld10", {31'd0, vld10}, 32'd0);
      chk("rst_busy10", {31'd0, busy10}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy10", {31'd0, busy10}, 32'd0);

      // GATE_DIV=1, period 10 -> 100 Hz, 1002 cycles after start.
      set_gen(10);
      repeat (30) @(negedge clk);
      c = cyc;
      q1.push_back('{32'd100, c + 1002});
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_empty(1, 1100);
      @(negedge clk);
      chk("dut1_busy_after", {31'd0, busy1}, 32'd0);

      // GATE_DIV=10, period 4 -> 250 Hz.
      set_gen(4);
      repeat (20) @(negedge clk);
      c = cyc;
      q10.push_back('{32'd250, c + 102});
      start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      wait_empty(10, 200);
      repeat (5) @(negedge clk);

      // Constant input -> 0 Hz; a start while busy is ignored.
      set_gen(0);
      repeat (10) @(negedge clk);
      c = cyc;
      q10.push_back('{32'd0, c + 102});
      chk("busy_before_start", {31'd0, busy10}, 32'd0);
      start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      chk("busy_first_gate", {31'd0, busy10}, 32'd1);
      wait_until(c + 30);
      start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      wait_until(c + 101);
      chk("busy_in_done", {31'd0, busy10}, 32'd1);
      @(negedge clk);
      chk("busy_end", {31'd0, busy10}, 32'd0);
      repeat (120) @(negedge clk);
      chk("busy_no_requeue", {31'd0, busy10}, 32'd0);
      wait_empty(10, 5);

      // start and cont together in one IDLE cycle -> single window.
      set_gen(4);
      repeat (20) @(negedge clk);
      c = cyc;
      q10.push_back('{32'd250, c + 102});
      start10 = 1'b1;
      cont10  = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      cont10  = 1'b0;
      wait_empty(10, 200);
      repeat (110) @(negedge clk);
      chk("startcont_idle", {31'd0, busy10}, 32'd0);

      // Continuous mode, period 5 -> 200 Hz every 101 cycles; drop cont
      // in the third window.
      set_gen(5);
      repeat (20) @(negedge clk);
      c = cyc;
      for (int j = 0; j < 3; j++) q10.push_back('{32'd200, c + 102 + 101 * j});
      cont10 = 1'b1;
      wait_until(c + 203);
      chk("cont_busy_between", {31'd0, busy10}, 32'd1);
      wait_until(c + 253);
      cont10 = 1'b0;
      wait_until(c + 305);
      chk("cont_busy_end", {31'd0, busy10}, 32'd0);
      repeat (110) @(negedge clk);
      chk("cont_hold_fo", fo10, 32'd200);
      wait_empty(10, 5);

      // Reset halfway through a gate.
      c = cyc;
      q10.push_back('{32'd200, c + 102});
      start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      wait_until(c + 50);
      rst_n = 1'b0;
      #1;
      chk("midrst_fo10", fo10, 32'd0);
      chk("midrst_vld10", {31'd0, vld10}, 32'd0);
      chk("midrst_busy10", {31'd0, busy10}, 32'd0);
      q10.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (150) @(negedge clk);
      chk("postrst_busy10", {31'd0, busy10}, 32'd0);
      chk("postrst_fo10", fo10, 32'd0);

      // Full window after reset.
      c = cyc;
      q10.push_back('{32'd200, c + 102});
      start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      wait_empty(10, 200);

      repeat (5) @(negedge clk);
      wait_empty(1, 1);
      wait_empty(10, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
